// File: rtl/bcd_disp_pkg.sv
// Shared constants for BCD counting and active-low seven-segment display.
package bcd_disp_pkg;

  localparam int unsigned BCD_W = 4;
  localparam int unsigned SEG_W = 7;

  // Active-low segment patterns, bit order gfedcba
  localparam logic [SEG_W-1:0] SEG_0     = 7'b1000000;
  localparam logic [SEG_W-1:0] SEG_1     = 7'b1111001;
  localparam logic [SEG_W-1:0] SEG_2     = 7'b0100100;
  localparam logic [SEG_W-1:0] SEG_3     = 7'b0110000;
  localparam logic [SEG_W-1:0] SEG_4     = 7'b0011001;
  localparam logic [SEG_W-1:0] SEG_5     = 7'b0010010;
  localparam logic [SEG_W-1:0] SEG_6     = 7'b0000010;
  localparam logic [SEG_W-1:0] SEG_7     = 7'b1111000;
  localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_9     = 7'b0010000;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD digit to active-low segment decoder with blanking.
module bcd_to_seg
  import bcd_disp_pkg::*;
(
  input  logic [BCD_W-1:0] digit,
  input  logic             blank,
  output logic [SEG_W-1:0] segs_c
);

  // Decode one digit; non-BCD codes and blanking both show nothing
  always_comb begin
    segs_c = SEG_BLANK;
    if (!blank) begin
      case (digit)
        4'd0:    segs_c = SEG_0;
        4'd1:    segs_c = SEG_1;
        4'd2:    segs_c = SEG_2;
        4'd3:    segs_c = SEG_3;
        4'd4:    segs_c = SEG_4;
        4'd5:    segs_c = SEG_5;
        4'd6:    segs_c = SEG_6;
        4'd7:    segs_c = SEG_7;
        4'd8:    segs_c = SEG_8;
        4'd9:    segs_c = SEG_9;
        default: segs_c = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/bcd_event_counter.sv
// Up/down BCD event counter driving a multiplexed common-anode display.
module bcd_event_counter
  import bcd_disp_pkg::*;
#(
  parameter int unsigned DIGITS      = 4,
  parameter int unsigned REFRESH_DIV = 100000,
  parameter bit          WRAP        = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    fire,
  input  logic                    error,
  input  logic                    down,
  input  logic                    clear,
  output logic [BCD_W*DIGITS-1:0] count_bcd,
  output logic                    rollover,
  output logic [DIGITS-1:0]       anode,
  output logic [SEG_W-1:0]        segs
);

  localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned BUS_W = BCD_W * DIGITS;

  localparam logic [CNT_W-1:0] REFRESH_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(DIGITS - 1);
  localparam logic [BUS_W-1:0] ALL_NINES    = {DIGITS{4'h9}};

  logic             sync1, sync2, fire_prev;
  logic             fire_pulse_c, accept_c;
  logic [BUS_W-1:0] count_inc_c, count_dec_c;
  logic             at_max_c, at_min_c;
  logic [CNT_W-1:0] refresh;
  logic [IDX_W-1:0] idx;
  logic [BCD_W-1:0] sel_digit_c;
  logic             sel_blank_c;
  logic [SEG_W-1:0] seg_c;

  // Bring the asynchronous fire input into clk and keep the previous level
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      fire_prev <= 1'b0;
    end else begin
      sync1     <= fire;
      sync2     <= sync1;
      fire_prev <= sync2;
    end
  end

  assign fire_pulse_c = sync2 & ~fire_prev;
  assign accept_c     = fire_pulse_c & enable & ~error & ~clear;

  // Ripple BCD increment/decrement and limit detection
  always_comb begin
    logic [BCD_W-1:0] d;
    logic             carry;
    logic             borrow;
    count_inc_c = '0;
    count_dec_c = '0;
    at_max_c    = 1'b1;
    at_min_c    = 1'b1;
    carry       = 1'b1;
    borrow      = 1'b1;
    d           = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      d = count_bcd[i*BCD_W +: BCD_W];
      if (d != 4'd9) at_max_c = 1'b0;
      if (d != 4'd0) at_min_c = 1'b0;
      if (carry) begin
        if (d == 4'd9) begin
          count_inc_c[i*BCD_W +: BCD_W] = 4'd0;
        end else begin
          count_inc_c[i*BCD_W +: BCD_W] = d + 4'd1;
          carry = 1'b0;
        end
      end else begin
        count_inc_c[i*BCD_W +: BCD_W] = d;
      end
      if (borrow) begin
        if (d == 4'd0) begin
          count_dec_c[i*BCD_W +: BCD_W] = 4'd9;
        end else begin
          count_dec_c[i*BCD_W +: BCD_W] = d - 4'd1;
          borrow = 1'b0;
        end
      end else begin
        count_dec_c[i*BCD_W +: BCD_W] = d;
      end
    end
  end

  // Count register; clear wins over an accepted event
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_bcd <= '0;
      rollover  <= 1'b0;
    end else if (clear) begin
      count_bcd <= '0;
      rollover  <= 1'b0;
    end else if (accept_c) begin
      if (down) begin
        if (at_min_c) begin
          rollover <= 1'b1;
          if (WRAP) count_bcd <= ALL_NINES;
        end else begin
          count_bcd <= count_dec_c;
        end
      end else begin
        if (at_max_c) begin
          rollover <= 1'b1;
          if (WRAP) count_bcd <= '0;
        end else begin
          count_bcd <= count_inc_c;
        end
      end
    end
  end

  // Refresh timer and digit index; free-running regardless of enable
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      refresh <= '0;
      idx     <= '0;
    end else if (refresh == REFRESH_LAST) begin
      refresh <= '0;
      idx     <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
    end else begin
      refresh <= refresh + CNT_W'(1);
    end
  end

  // Select the lit digit and blank it if it is a leading zero
  always_comb begin
    logic             upper_zero;
    logic [BCD_W-1:0] d;
    sel_digit_c = '0;
    sel_blank_c = 1'b0;
    upper_zero  = 1'b1;
    d           = '0;
    for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
      d          = count_bcd[i*BCD_W +: BCD_W];
      upper_zero = upper_zero & (d == 4'd0);
      if (idx == IDX_W'(i)) begin
        sel_digit_c = d;
        sel_blank_c = (i != 0) && upper_zero;
      end
    end
  end

  bcd_to_seg u_seg (
    .digit  (sel_digit_c),
    .blank  (sel_blank_c),
    .segs_c (seg_c)
  );

  // Registered display drive; everything dark while disabled
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      anode <= '1;
      segs  <= SEG_BLANK;
    end else if (enable) begin
      anode <= ~(DIGITS'(1) << idx);
      segs  <= seg_c;
    end else begin
      anode <= '1;
      segs  <= SEG_BLANK;
    end
  end

endmodule

// File: tb/tb_bcd_event_counter.sv
// Self-checking bench: a 4-digit wrapping counter and a 3-digit saturating one share stimulus.
module tb_bcd_event_counter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b1;
  logic        fire = 1'b0;
  logic        error = 1'b0;
  logic        down = 1'b0;
  logic        clear = 1'b0;

  logic [15:0] cw;
  logic        rw;
  logic [3:0]  anode_w;
  logic [6:0]  segs_w;
  logic [11:0] cs;
  logic        rs;
  logic [2:0]  anode_s;
  logic [6:0]  segs_s;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc;

  // Reference model state: plain integer counts
  int mw = 0;
  int ms = 0;
  bit mrw = 1'b0;
  bit mrs = 1'b0;

  bcd_event_counter #(.DIGITS(4), .REFRESH_DIV(4), .WRAP(1'b1)) u_wrap (
    .clk(clk), .reset(reset), .enable(enable), .fire(fire), .error(error),
    .down(down), .clear(clear), .count_bcd(cw), .rollover(rw),
    .anode(anode_w), .segs(segs_w));

  bcd_event_counter #(.DIGITS(3), .REFRESH_DIV(4), .WRAP(1'b0)) u_sat (
    .clk(clk), .reset(reset), .enable(enable), .fire(fire), .error(error),
    .down(down), .clear(clear), .count_bcd(cs), .rollover(rs),
    .anode(anode_s), .segs(segs_s));

  always #5 clk = ~clk;

  always @(posedge clk or negedge reset) begin
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] to_bcd(input int v);
    logic [31:0] r;
    int p;
    r = '0;
    p = 1;
    for (int i = 0; i < 8; i++) begin
      r[i*4 +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  function automatic logic [6:0] seg_of(input int v, input int i);
    int p;
    p = 1;
    for (int k = 0; k < i; k++) p = p * 10;
    if (i > 0 && v / p == 0) return 7'h7F;
    case ((v / p) % 10)
      0: return 7'h40;
      1: return 7'h79;
      2: return 7'h24;
      3: return 7'h30;
      4: return 7'h19;
      5: return 7'h12;
      6: return 7'h02;
      7: return 7'h78;
      8: return 7'h00;
      default: return 7'h10;
    endcase
  endfunction

  // One counting step on an integer, with limit handling
  function automatic void step(input int maxv, input bit wrap, input bit dn,
                               inout int c, inout bit r);
    if (dn) begin
      if (c == 0) begin r = 1'b1; if (wrap) c = maxv; end
      else c = c - 1;
    end else begin
      if (c == maxv) begin r = 1'b1; if (wrap) c = 0; end
      else c = c + 1;
    end
  endfunction

  function automatic void model_event();
    if (clear) begin
      mw = 0; ms = 0; mrw = 1'b0; mrs = 1'b0;
    end else if (enable && !error) begin
      step(9999, 1'b1, down, mw, mrw);
      step(999, 1'b0, down, ms, mrs);
    end
  endfunction

  // Called at a negedge; control inputs are held through the whole event
  task automatic fire_event(input int hi, input int lo);
    fire = 1'b1;
    repeat (hi) @(negedge clk);
    fire = 1'b0;
    repeat (lo) @(negedge clk);
    model_event();
  endtask

  task automatic check_counts(input string nm);
    check({nm, "_count_w"}, 32'(cw), to_bcd(mw));
    check({nm, "_roll_w"},  32'(rw), 32'(mrw));
    check({nm, "_count_s"}, 32'(cs), to_bcd(ms));
    check({nm, "_roll_s"},  32'(rs), 32'(mrs));
  endtask

  task automatic check_display(input string nm, input int n);
    logic [3:0] ea_w;
    logic [2:0] ea_s;
    int iw, is;
    repeat (n) begin
      @(posedge clk); #1;
      iw = ((cyc - 1) / 4) % 4;
      is = ((cyc - 1) / 4) % 3;
      ea_w = 4'hF;
      ea_s = 3'h7;
      if (enable) begin
        ea_w[iw] = 1'b0;
        ea_s[is] = 1'b0;
      end
      check({nm, "_anode_w"}, 32'(anode_w), 32'(ea_w));
      check({nm, "_segs_w"},  32'(segs_w), enable ? 32'(seg_of(mw, iw)) : 32'h7F);
      check({nm, "_anode_s"}, 32'(anode_s), 32'(ea_s));
      check({nm, "_segs_s"},  32'(segs_s), enable ? 32'(seg_of(ms, is)) : 32'h7F);
    end
    @(negedge clk);
  endtask

  typedef struct {
    bit          dn;
    bit          err;
    bit          en;
    int          n;
    logic [15:0] ew;
    bit          erw;
    logic [11:0] es;
    bit          ers;
  } vec_t;

  vec_t tbl[5];

  initial begin
    tbl[0] = '{dn:1'b0, err:1'b0, en:1'b1, n:12, ew:16'h0012, erw:1'b0, es:12'h012, ers:1'b0};
    tbl[1] = '{dn:1'b0, err:1'b1, en:1'b1, n:5,  ew:16'h0012, erw:1'b0, es:12'h012, ers:1'b0};
    tbl[2] = '{dn:1'b0, err:1'b0, en:1'b0, n:5,  ew:16'h0012, erw:1'b0, es:12'h012, ers:1'b0};
    tbl[3] = '{dn:1'b1, err:1'b0, en:1'b1, n:13, ew:16'h9999, erw:1'b1, es:12'h000, ers:1'b1};
    tbl[4] = '{dn:1'b0, err:1'b0, en:1'b1, n:1,  ew:16'h0000, erw:1'b1, es:12'h001, ers:1'b1};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_count_w", 32'(cw), 32'h0);
    check("rst_roll_w", 32'(rw), 32'h0);
    check("rst_anode_w", 32'(anode_w), 32'hF);
    check("rst_segs_w", 32'(segs_w), 32'h7F);
    reset = 1'b1;
    check_display("disp_after_rst", 16);

    // Table-driven sequences
    for (int i = 0; i < 5; i++) begin
      down = tbl[i].dn;
      error = tbl[i].err;
      enable = tbl[i].en;
      for (int k = 0; k < tbl[i].n; k++) fire_event(2, 2);
      check($sformatf("tbl%0d_count_w", i), 32'(cw), 32'(tbl[i].ew));
      check($sformatf("tbl%0d_roll_w", i),  32'(rw), 32'(tbl[i].erw));
      check($sformatf("tbl%0d_count_s", i), 32'(cs), 32'(tbl[i].es));
      check($sformatf("tbl%0d_roll_s", i),  32'(rs), 32'(tbl[i].ers));
      if (i == 0 || i == 2) check_display($sformatf("tbl%0d_disp", i), 12);
    end
    down = 1'b0; error = 1'b0; enable = 1'b1;

    // Plain clear
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    mw = 0; ms = 0; mrw = 1'b0; mrs = 1'b0;
    @(negedge clk);
    check_counts("clear");

    // Count to 42, then clear in the same cycle as an event pulse
    for (int k = 0; k < 42; k++) fire_event(2, 2);
    check_counts("to42");
    check_display("disp42", 12);
    fire = 1'b1;
    @(negedge clk);
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    fire = 1'b0;
    repeat (3) @(negedge clk);
    mw = 0; ms = 0; mrw = 1'b0; mrs = 1'b0;
    check_counts("clr_evt");

    // Latency: update lands on the third edge after fire rises
    fire_event(2, 2);
    fire = 1'b1;
    @(posedge clk); #1;
    check("lat_k_w", 32'(cw), to_bcd(mw));
    @(posedge clk); #1;
    check("lat_k1_w", 32'(cw), to_bcd(mw));
    @(posedge clk); #1;
    step(9999, 1'b1, 1'b0, mw, mrw);
    step(999, 1'b0, 1'b0, ms, mrs);
    check("lat_k2_w", 32'(cw), to_bcd(mw));
    check("lat_k2_s", 32'(cs), to_bcd(ms));
    @(negedge clk);
    fire = 1'b0;
    repeat (2) @(negedge clk);

    // Sub-cycle glitch between edges is never seen
    @(posedge clk); #2;
    fire = 1'b1;
    #2;
    fire = 1'b0;
    repeat (4) @(negedge clk);
    check_counts("glitch");

    // Drive the 3-digit saturating counter to its ceiling
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    mw = 0; ms = 0; mrw = 1'b0; mrs = 1'b0;
    for (int k = 0; k < 999; k++) fire_event(2, 2);
    check_counts("to999");
    fire_event(2, 2);
    check_counts("sat_up");
    check_display("disp_sat", 12);

    // Randomized traffic against the model
    for (int k = 0; k < 300; k++) begin
      down = 1'($urandom_range(0, 1));
      error = ($urandom_range(0, 7) == 0);
      enable = ($urandom_range(0, 7) != 0);
      clear = ($urandom_range(0, 15) == 0);
      fire_event(int'($urandom_range(2, 3)), int'($urandom_range(2, 4)));
      clear = 1'b0;
      check_counts($sformatf("rand%0d", k));
    end
    down = 1'b0; error = 1'b0; enable = 1'b1;
    @(negedge clk);
    check_display("disp_rand", 12);

    // Asynchronous reset in the middle of a refresh period
    fire_event(2, 2);
    fire_event(2, 2);
    @(posedge clk); #3;
    reset = 1'b0;
    #1;
    check("mid_rst_count_w", 32'(cw), 32'h0);
    check("mid_rst_count_s", 32'(cs), 32'h0);
    check("mid_rst_roll_w", 32'(rw), 32'h0);
    check("mid_rst_anode_w", 32'(anode_w), 32'hF);
    check("mid_rst_segs_w", 32'(segs_w), 32'h7F);
    mw = 0; ms = 0; mrw = 1'b0; mrs = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check_display("disp_post_rst", 16);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
